// File: rtl/pc_stack_unit.sv
// Program counter with increment/jump/branch/call/return and a hardware
// return-address stack. The stack is indexed by its registered depth.
module pc_stack_unit #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int INC_STEP    = 1,
    parameter int RESET_ADDR  = 0
) (
    input  logic                               clk,
    input  logic                               clr,
    input  logic                               en_pc,
    input  logic [2:0]                         op,
    input  logic [ADDR_W-1:0]                  adrs_in,
    input  logic [ADDR_W-1:0]                  offset,
    input  logic                               cond,
    input  logic                               err_clr,
    output logic [ADDR_W-1:0]                  adrs_out,
    output logic [ADDR_W-1:0]                  ret_addr,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stk_full,
    output logic                               stk_empty,
    output logic                               stk_ovf,
    output logic                               stk_unf,
    output logic                               op_err
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INC_STEP);
    localparam logic [ADDR_W-1:0] RST  = ADDR_W'(RESET_ADDR);
    localparam logic [DW-1:0]     FULL = DW'(STACK_DEPTH);

    typedef enum logic [2:0] {
        OP_INC    = 3'b000,
        OP_JUMP   = 3'b001,
        OP_BRANCH = 3'b010,
        OP_CALL   = 3'b011,
        OP_RET    = 3'b100,
        OP_HOLD   = 3'b101,
        OP_RSV6   = 3'b110,
        OP_RSV7   = 3'b111
    } op_t;

    op_t               op_sel;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic              push;
    logic              pop;
    logic              ovf_ev;
    logic              unf_ev;
    logic              op_ev;

    assign op_sel    = op_t'(op);
    assign pc_inc    = pc + STEP;
    assign adrs_out  = pc;
    assign stk_full  = (depth == FULL);
    assign stk_empty = (depth == '0);

    always_comb begin
        ret_addr = '0;
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (depth == DW'(i + 1)) ret_addr = stack[i];
        end
    end

    always_comb begin
        pc_nxt = pc;
        push   = 1'b0;
        pop    = 1'b0;
        ovf_ev = 1'b0;
        unf_ev = 1'b0;
        op_ev  = 1'b0;
        if (en_pc) begin
            case (op_sel)
                OP_INC:    pc_nxt = pc_inc;
                OP_JUMP:   pc_nxt = adrs_in;
                // Equal-width modular add is the same as sign-extended add.
                OP_BRANCH: pc_nxt = cond ? pc + offset : pc_inc;
                OP_CALL: begin
                    pc_nxt = adrs_in;
                    push   = !stk_full;
                    ovf_ev = stk_full;
                end
                OP_RET: begin
                    pc_nxt = stk_empty ? pc_inc : ret_addr;
                    pop    = !stk_empty;
                    unf_ev = stk_empty;
                end
                OP_HOLD:   pc_nxt = pc;
                default: begin
                    pc_nxt = pc_inc;
                    op_ev  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc      <= RST;
            depth   <= '0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
            op_err  <= 1'b0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
        end else begin
            pc <= pc_nxt;
            if (push) begin
                for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                    if (depth == DW'(i)) stack[i] <= pc_inc;
                end
                depth <= depth + DW'(1);
            end else if (pop) begin
                depth <= depth - DW'(1);
            end
            // A new error event on the same edge overrides err_clr.
            stk_ovf <= ovf_ev | (stk_ovf & ~err_clr);
            stk_unf <= unf_ev | (stk_unf & ~err_clr);
            op_err  <= op_ev  | (op_err  & ~err_clr);
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: a behavioural model predicts each
// enabled step, and a monitor compares one cycle after the sampling edge.
module tb_pc_stack_unit;

    logic       clk = 1'b0;
    logic       clr;
    logic       en_pc, cond, err_clr;
    logic [2:0] op;
    logic [7:0] adrs_in, offset;
    logic [7:0] adrs_out, ret_addr;
    logic [2:0] depth;
    logic       stk_full, stk_empty, stk_ovf, stk_unf, op_err;

    logic        en2, cond2, ec2;
    logic [2:0]  op2;
    logic [11:0] a2, off2, adrs2, ret2;
    logic [0:0]  depth2;
    logic        full2, empty2, ovf2, unf2, operr2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_stack_unit #(.ADDR_W(8), .STACK_DEPTH(4), .INC_STEP(1), .RESET_ADDR(0)) dut (
        .clk(clk), .clr(clr), .en_pc(en_pc), .op(op), .adrs_in(adrs_in),
        .offset(offset), .cond(cond), .err_clr(err_clr), .adrs_out(adrs_out),
        .ret_addr(ret_addr), .depth(depth), .stk_full(stk_full),
        .stk_empty(stk_empty), .stk_ovf(stk_ovf), .stk_unf(stk_unf), .op_err(op_err)
    );

    pc_stack_unit #(.ADDR_W(12), .STACK_DEPTH(1), .INC_STEP(2), .RESET_ADDR(0)) dut2 (
        .clk(clk), .clr(clr), .en_pc(en2), .op(op2), .adrs_in(a2),
        .offset(off2), .cond(cond2), .err_clr(ec2), .adrs_out(adrs2),
        .ret_addr(ret2), .depth(depth2), .stk_full(full2),
        .stk_empty(empty2), .stk_ovf(ovf2), .stk_unf(unf2), .op_err(operr2)
    );

    typedef struct packed {
        logic [7:0] pc;
        logic [2:0] dep;
        logic [7:0] ret;
        logic [4:0] fl;   // {full, empty, ovf, unf, op_err}
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_pc;
    logic [7:0] m_stk[$];
    logic       m_ovf, m_unf, m_op;

    function automatic exp_t model_state();
        exp_t e;
        e.pc  = m_pc;
        e.dep = 3'(m_stk.size());
        e.ret = (m_stk.size() > 0) ? m_stk[$] : 8'h00;
        e.fl  = {m_stk.size() == 4, m_stk.size() == 0, m_ovf, m_unf, m_op};
        return e;
    endfunction

    task automatic model_reset();
        m_pc = 8'h00;
        m_stk.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_op = 1'b0;
    endtask

    // Drive one cycle on the 8-bit DUT, predict the result and queue it.
    task automatic drive(input logic en, input logic [2:0] o, input logic [7:0] a,
                         input logic [7:0] off, input logic c, input logic ec);
        @(negedge clk);
        en_pc = en; op = o; adrs_in = a; offset = off; cond = c; err_clr = ec;
        if (ec) begin m_ovf = 1'b0; m_unf = 1'b0; m_op = 1'b0; end
        if (en) begin
            case (o)
                3'd0: m_pc = m_pc + 8'd1;
                3'd1: m_pc = a;
                3'd2: m_pc = c ? m_pc + off : m_pc + 8'd1;
                3'd3: begin
                    if (m_stk.size() < 4) m_stk.push_back(m_pc + 8'd1);
                    else m_ovf = 1'b1;
                    m_pc = a;
                end
                3'd4: begin
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else begin m_pc = m_pc + 8'd1; m_unf = 1'b1; end
                end
                3'd5: ;
                default: begin m_pc = m_pc + 8'd1; m_op = 1'b1; end
            endcase
        end
        sb.push_back(model_state());
        @(posedge clk);
        #2;
        en_pc = 1'b0; err_clr = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_chk += 4;
            if (adrs_out !== e.pc) begin
                n_fail++; $display("FAIL sb_pc: got %h expected %h", adrs_out, e.pc);
            end
            if (depth !== e.dep) begin
                n_fail++; $display("FAIL sb_depth: got %0d expected %0d", depth, e.dep);
            end
            if (ret_addr !== e.ret) begin
                n_fail++; $display("FAIL sb_ret: got %h expected %h", ret_addr, e.ret);
            end
            if ({stk_full, stk_empty, stk_ovf, stk_unf, op_err} !== e.fl) begin
                n_fail++;
                $display("FAIL sb_flags: got %b expected %b",
                         {stk_full, stk_empty, stk_ovf, stk_unf, op_err}, e.fl);
            end
        end
    end

    task automatic test_reset();
        clr = 1'b0; en_pc = 1'b0; op = 3'd0; adrs_in = '0; offset = '0;
        cond = 1'b0; err_clr = 1'b0;
        en2 = 1'b0; op2 = 3'd0; a2 = '0; off2 = '0; cond2 = 1'b0; ec2 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({adrs_out, depth, ret_addr, stk_full, stk_empty, stk_ovf, stk_unf, op_err}
            !== {8'h00, 3'd0, 8'h00, 5'b01000}) begin
            n_fail++; $display("FAIL reset_state: got pc=%h depth=%0d", adrs_out, depth);
        end
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic test_inc_hold();
        drive(1, 3'd1, 8'h30, 8'h00, 0, 0);
        drive(1, 3'd3, 8'h37, 8'h00, 0, 0);
        n_chk++;
        if (adrs_out !== 8'h37 || depth !== 3'd1) begin
            n_fail++; $display("FAIL pre_reset: got pc=%h depth=%0d expected 37/1", adrs_out, depth);
        end
        #3 clr = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (adrs_out !== 8'h00 || depth !== 3'd0 || stk_empty !== 1'b1 || ret_addr !== 8'h00) begin
            n_fail++; $display("FAIL async_reset: got pc=%h depth=%0d expected 00/0", adrs_out, depth);
        end
        @(negedge clk);
        clr = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1, 3'd0, 8'h00, 8'h00, 0, 0);
            n_chk++;
            if (adrs_out !== 8'(i)) begin
                n_fail++; $display("FAIL inc_%0d: got %h expected %h", i, adrs_out, 8'(i));
            end
        end
        drive(0, 3'd1, 8'hAA, 8'h00, 1, 0);
        drive(0, 3'd3, 8'hBB, 8'h00, 1, 0);
        n_chk++;
        if (adrs_out !== 8'h03 || depth !== 3'd0) begin
            n_fail++; $display("FAIL stall_hold: got pc=%h depth=%0d expected 03/0", adrs_out, depth);
        end
    endtask

    task automatic test_wrap_branch();
        drive(1, 3'd1, 8'hFE, 8'h00, 0, 0);
        drive(1, 3'd0, 8'h00, 8'h00, 0, 0);
        drive(1, 3'd0, 8'h00, 8'h00, 0, 0);
        n_chk++;
        if (adrs_out !== 8'h00) begin
            n_fail++; $display("FAIL wrap: got %h expected 00", adrs_out);
        end
        drive(1, 3'd1, 8'h10, 8'h00, 0, 0);
        drive(1, 3'd2, 8'h00, 8'hF8, 1, 0);
        n_chk++;
        if (adrs_out !== 8'h08) begin
            n_fail++; $display("FAIL branch_taken: got %h expected 08", adrs_out);
        end
        drive(1, 3'd1, 8'h10, 8'h00, 0, 0);
        drive(1, 3'd2, 8'h00, 8'hF8, 0, 0);
        n_chk++;
        if (adrs_out !== 8'h11) begin
            n_fail++; $display("FAIL branch_not_taken: got %h expected 11", adrs_out);
        end
        drive(1, 3'd5, 8'h55, 8'h00, 0, 0);
        n_chk++;
        if (adrs_out !== 8'h11) begin
            n_fail++; $display("FAIL hold_op: got %h expected 11", adrs_out);
        end
    endtask

    task automatic test_nested_calls();
        drive(1, 3'd1, 8'h20, 8'h00, 0, 0);
        drive(1, 3'd3, 8'h40, 8'h00, 0, 0);
        drive(1, 3'd3, 8'h60, 8'h00, 0, 0);
        n_chk++;
        if (depth !== 3'd2 || ret_addr !== 8'h41 || adrs_out !== 8'h60) begin
            n_fail++; $display("FAIL nested_call: got depth=%0d ret=%h expected 2/41", depth, ret_addr);
        end
        drive(1, 3'd4, 8'h00, 8'h00, 0, 0);
        n_chk++;
        if (adrs_out !== 8'h41 || depth !== 3'd1) begin
            n_fail++; $display("FAIL ret1: got pc=%h depth=%0d expected 41/1", adrs_out, depth);
        end
        drive(1, 3'd4, 8'h00, 8'h00, 0, 0);
        n_chk++;
        if (adrs_out !== 8'h21 || depth !== 3'd0 || stk_empty !== 1'b1) begin
            n_fail++; $display("FAIL ret2: got pc=%h depth=%0d expected 21/0", adrs_out, depth);
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 3'd1, 8'h50, 8'h00, 0, 0);
        drive(1, 3'd3, 8'h90, 8'h00, 0, 0);
        drive(1, 3'd4, 8'h00, 8'h00, 0, 0);
        n_chk++;
        if (adrs_out !== 8'h51 || depth !== 3'd0) begin
            n_fail++; $display("FAIL call_ret_b2b: got pc=%h depth=%0d expected 51/0", adrs_out, depth);
        end
    endtask

    task automatic test_overflow();
        drive(1, 3'd1, 8'h00, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 3'd3, 8'h80 + 8'(i), 8'h00, 0, 0);
        n_chk++;
        if (adrs_out !== 8'h84 || depth !== 3'd4 || stk_full !== 1'b1 || stk_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: got pc=%h depth=%0d full=%b ovf=%b expected 84/4/1/1",
                     adrs_out, depth, stk_full, stk_ovf);
        end
        // Entries are 01,81,82,83; the fifth push was dropped.
        for (int i = 0; i < 4; i++) begin
            logic [7:0] want;
            want = (i == 3) ? 8'h01 : 8'h83 - 8'(i);
            drive(1, 3'd4, 8'h00, 8'h00, 0, 0);
            n_chk++;
            if (adrs_out !== want) begin
                n_fail++; $display("FAIL ovf_ret_%0d: got %h expected %h", i, adrs_out, want);
            end
        end
    endtask

    task automatic test_underflow_errors();
        drive(1, 3'd1, 8'h05, 8'h00, 0, 1);
        n_chk++;
        if (stk_ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear: got %b expected 0", stk_ovf);
        end
        drive(1, 3'd4, 8'h00, 8'h00, 0, 0);
        n_chk++;
        if (adrs_out !== 8'h06 || stk_unf !== 1'b1 || depth !== 3'd0) begin
            n_fail++; $display("FAIL underflow: got pc=%h unf=%b expected 06/1", adrs_out, stk_unf);
        end
        drive(1, 3'd7, 8'h00, 8'h00, 0, 0);
        n_chk++;
        if (op_err !== 1'b1 || adrs_out !== 8'h07) begin
            n_fail++; $display("FAIL op_err: got err=%b pc=%h expected 1/07", op_err, adrs_out);
        end
        drive(1, 3'd5, 8'h00, 8'h00, 0, 1);
        n_chk++;
        if ({stk_ovf, stk_unf, op_err} !== 3'b000) begin
            n_fail++; $display("FAIL err_clr: got %b expected 000", {stk_ovf, stk_unf, op_err});
        end
        drive(1, 3'd6, 8'h00, 8'h00, 0, 0);
        drive(0, 3'd7, 8'h00, 8'h00, 0, 1);
        n_chk++;
        if (op_err !== 1'b0 || adrs_out !== 8'h08) begin
            n_fail++; $display("FAIL err_clr_stalled: got err=%b pc=%h expected 0/08", op_err, adrs_out);
        end
        drive(1, 3'd4, 8'h00, 8'h00, 0, 0);
        drive(1, 3'd4, 8'h00, 8'h00, 0, 1);
        n_chk++;
        if (stk_unf !== 1'b1 || adrs_out !== 8'h0A) begin
            n_fail++; $display("FAIL clr_vs_event: got unf=%b pc=%h expected 1/0a", stk_unf, adrs_out);
        end
    endtask

    task automatic test_param_sweep();
        logic [11:0] exp_q[$];
        logic [11:0] want;
        @(negedge clk); en2 = 1'b1; op2 = 3'd1; a2 = 12'hFFE; exp_q.push_back(12'hFFE);
        @(negedge clk); op2 = 3'd3; a2 = 12'h100;              exp_q.push_back(12'h100);
        @(posedge clk); #1;
        // First pop is the JUMP result, already overwritten; check it via drop order.
        want = exp_q.pop_front();
        want = exp_q.pop_front();
        n_chk++;
        if (adrs2 !== want || ret2 !== 12'h000 || depth2 !== 1'b1 || full2 !== 1'b1) begin
            n_fail++;
            $display("FAIL p_call: got pc=%h ret=%h depth=%0d full=%b expected %h/000/1/1",
                     adrs2, ret2, depth2, full2, want);
        end
        @(negedge clk); op2 = 3'd3; a2 = 12'h200; exp_q.push_back(12'h200);
        @(posedge clk); #1;
        want = exp_q.pop_front();
        n_chk++;
        if (adrs2 !== want || ovf2 !== 1'b1 || depth2 !== 1'b1) begin
            n_fail++; $display("FAIL p_ovf: got pc=%h ovf=%b expected %h/1", adrs2, ovf2, want);
        end
        @(negedge clk); op2 = 3'd4; exp_q.push_back(12'h000);
        @(posedge clk); #1;
        want = exp_q.pop_front();
        n_chk++;
        if (adrs2 !== want || depth2 !== 1'b0 || empty2 !== 1'b1) begin
            n_fail++; $display("FAIL p_ret: got pc=%h depth=%0d expected %h/0", adrs2, depth2, want);
        end
        @(negedge clk); op2 = 3'd0; exp_q.push_back(12'h002);
        @(posedge clk); #1;
        want = exp_q.pop_front();
        n_chk++;
        if (adrs2 !== want) begin
            n_fail++; $display("FAIL p_inc: got %h expected %h", adrs2, want);
        end
        en2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_inc_hold();
        test_wrap_branch();
        test_nested_calls();
        test_back_to_back();
        test_overflow();
        test_underflow_errors();
        test_param_sweep();
        repeat (3) @(posedge clk);
        #3;
        n_chk++;
        if (sb.size() !== 0) begin
            n_fail++; $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
